// File: rtl/alu_seq_n_if.sv
// Operand/result handshake bundle for alu_seq_n.
// master = operand producer and result consumer; slave = the ALU.
interface alu_seq_n_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, res_lo, res_hi, zero, busy
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, res_lo, res_hi, zero, busy
  );
endinterface

// File: rtl/alu_seq_n.sv
// Registered 16-opcode ALU with a 2*WIDTH result and flags, valid/ready on both sides.
// Multiply runs as a WIDTH-cycle shift-add engine; all other ops complete in one cycle.
module alu_seq_n #(
  parameter int unsigned WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  alu_seq_n_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [3:0] OpMul = 4'b1100;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   res_lo_q, res_hi_q;
  logic               zero_q, out_valid_q, busy_q;
  logic [WIDTH-1:0]   mcand_q;
  // Upper half accumulates partial sums; lower half holds the not-yet-consumed multiplier bits.
  logic [2*WIDTH-1:0] prod_q;
  logic [CntW-1:0]    cnt_q;

  logic               in_ready;
  logic               accept;
  logic [2*WIDTH-1:0] op_res;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StMul:   in_ready = 1'b0;
      StDone:  in_ready = bus.out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid & in_ready;

  always_comb begin
    op_res  = '0;
    add_ext = {1'b0, bus.a} + {1'b0, bus.b};
    case (bus.opcode)
      4'b0000: op_res[0] = |bus.a;
      4'b0001: op_res[0] = &bus.a;
      4'b0010: op_res[0] = ^bus.a;
      4'b0011: op_res[WIDTH-1:0] = bus.a & bus.b;
      4'b0100: op_res[WIDTH-1:0] = bus.a | bus.b;
      4'b0101: op_res[WIDTH-1:0] = bus.a ^ bus.b;
      4'b0110: op_res[0] = bus.a > bus.b;
      4'b0111: op_res[0] = bus.a < bus.b;
      4'b1000: op_res[0] = bus.a == '0;
      4'b1001: op_res[0] = bus.a == bus.b;
      4'b1010: op_res[WIDTH:0] = add_ext;
      4'b1011: begin
        op_res[WIDTH-1:0] = bus.a - bus.b;
        op_res[WIDTH]     = bus.a < bus.b;
      end
      4'b1100: op_res = '0;
      4'b1101: op_res[WIDTH-1:0] = bus.a >> bus.b;
      4'b1110: op_res = {{WIDTH{1'b0}}, bus.a} << bus.b;
      4'b1111: op_res[WIDTH-1:0] = ~bus.b;
      default: op_res = '0;
    endcase
  end

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
    prod_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            if (bus.opcode == OpMul) begin
              mcand_q     <= bus.a;
              prod_q      <= {{WIDTH{1'b0}}, bus.b};
              cnt_q       <= '0;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
              state_q     <= StMul;
            end else begin
              res_lo_q    <= op_res[WIDTH-1:0];
              res_hi_q    <= op_res[2*WIDTH-1:WIDTH];
              zero_q      <= ~|op_res;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end
          end else if (state_q == StDone && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StMul: begin
          prod_q <= prod_next;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            res_lo_q    <= prod_next[WIDTH-1:0];
            res_hi_q    <= prod_next[2*WIDTH-1:WIDTH];
            zero_q      <= ~|prod_next;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.res_lo    = res_lo_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/alu_seq_n.md
Name: alu_seq_n

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the same 16-opcode set, generalised to WIDTH bits. Every result goes to a double-width output with flags, behind valid/ready handshakes. Multiply is a multi-cycle shift-add engine. The block sits between the operand-fetch stage and the writeback register, and may stall in either direction.

Parameters:
WIDTH, 8, operand width in bits (min 2). Result is 2*WIDTH bits, split as res_hi:res_lo.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and opcode valid
in_ready  output  1  block accepts operands this cycle
opcode  input  4  operation select
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned; also the shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
res_lo  output  WIDTH  result low half
res_hi  output  WIDTH  result high half / carry / borrow
zero  output  1  high when {res_hi,res_lo} == 0
busy  output  1  high while in the MUL state

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - res_lo, res_hi, zero, out_valid, busy = 0.
  - Internal multiplier regs and counter = 0.
  - Reset mid-multiply abandons the operation. No result is ever presented for it.
- States:
  - IDLE: in_ready = 1.
  - MUL: in_ready = 0, busy = 1.
  - DONE: out_valid = 1, in_ready = out_ready.
- Accept = in_valid & in_ready.
- Accept of a non-multiply opcode:
  - Result is registered at the same edge.
  - Next state is DONE, so out_valid is high the cycle after accept (latency 1).
- Accept of opcode 1100:
  - a and b are latched, accumulator and counter cleared, next state MUL.
  - Each MUL cycle performs one shift-add iteration.
  - After exactly WIDTH iterations, the product is written and the state goes to DONE.
  - out_valid therefore rises WIDTH edges after the accepting edge.
  - Opcode changes during MUL are ignored.
- In DONE with out_ready = 0:
  - res_lo, res_hi and zero are held stable.
  - in_ready = 0.
- In DONE with out_ready = 1:
  - The result is consumed.
  - If in_valid is also high at the same edge, the new op is accepted (back-to-back, one result per cycle for non-multiply ops).
  - Otherwise the state goes to IDLE and out_valid falls.
- Outputs change only on an accept or on multiply completion.
- zero is computed from the full 2*WIDTH result in the same cycle the result is registered.
- Opcodes (any unspecified result bits are 0):
  - 0000: res_lo[0] = |a
  - 0001: res_lo[0] = &a
  - 0010: res_lo[0] = ^a
  - 0011: res_lo = a & b
  - 0100: res_lo = a | b
  - 0101: res_lo = a ^ b
  - 0110: res_lo[0] = (a > b), unsigned
  - 0111: res_lo[0] = (a < b), unsigned
  - 1000: res_lo[0] = (a == 0)
  - 1001: res_lo[0] = (a == b)
  - 1010: res_lo = (a + b) mod 2^WIDTH; res_hi[0] = carry out
  - 1011: res_lo = (a - b) mod 2^WIDTH; res_hi[0] = borrow (a < b)
  - 1100: {res_hi,res_lo} = a * b, full 2*WIDTH-bit product
  - 1101: res_lo = a >> b (logical); res_hi = 0; b >= WIDTH gives 0
  - 1110: {res_hi,res_lo} = zero-extended a << b; b >= 2*WIDTH gives 0
  - 1111: res_lo = ~b
- All 16 opcodes are defined. There is no error path and no latch-like partial update.
- Simultaneous in_valid during MUL or a stalled DONE is not accepted. The producer must hold its inputs until in_ready is high.

Test Plan:
WIDTH = 8 for all scenarios.
1. Add: opcode 1010, a = 200, b = 100, out_ready = 1.
   -> Next cycle: out_valid = 1, res_lo = 0x2C, res_hi = 0x01, zero = 0.
2. Subtract: opcode 1011, a = 5, b = 7.
   -> res_lo = 0xFE, res_hi = 0x01.
   Then opcode 1001, a = b = 0x33 -> res_lo = 0x01.
   Then opcode 0011, a = 0xF0, b = 0x0F -> zero = 1.
3. Multiply: opcode 1100, a = 0xFF, b = 0xFF.
   -> busy = 1 and in_ready = 0 for 8 cycles.
   -> out_valid rises 8 edges after accept with res_hi = 0xFE, res_lo = 0x01.
   Also: 0 * 0xAB gives zero = 1.
4. Shifts: opcode 1110, a = 0x81, b = 4.
   -> res_hi = 0x08, res_lo = 0x10.
   Opcode 1110, b = 16 -> all zero, zero = 1.
   Opcode 1101, a = 0x80, b = 7 -> res_lo = 0x01.
5. Backpressure and throughput:
   - Hold out_ready = 0 for 5 cycles after a result: result stays stable and in_ready = 0.
   - Then stream 4 back-to-back XOR ops with out_ready = 1: 4 results on 4 consecutive cycles, in order.
6. Reset mid-multiply: drop rst_n 3 cycles into a multiply.
   -> All outputs 0 immediately, without waiting for a clock edge.
   -> After release: in_ready = 1, out_valid stays 0 until a new accept.
